// File: rtl/wb_retire_buf_if.sv
// wb_retire_buf_if: upstream entry, register-file write and commit/flush signals of the retire buffer.
interface wb_retire_buf_if #(
    parameter int XLEN   = 32,
    parameter int EXC_N  = 14,
    parameter int REG_AW = 5
);
    localparam int EW = $clog2(EXC_N);
    logic              in_valid;
    logic              in_ready;
    logic              in_we;
    logic [REG_AW-1:0] in_waddr;
    logic [XLEN-1:0]   in_wdata;
    logic [XLEN-1:0]   in_pc;
    logic [EXC_N-1:0]  in_exc;
    logic              in_ertn;
    logic              in_refetch;
    logic              rf_ready;
    logic              rf_we;
    logic [REG_AW-1:0] rf_waddr;
    logic [XLEN-1:0]   rf_wdata;
    logic              commit_valid;
    logic [XLEN-1:0]   commit_pc;
    logic              flush;
    logic              flush_excep;
    logic              flush_ertn;
    logic              flush_refetch;
    logic [EW-1:0]     exc_idx;
    logic [XLEN-1:0]   flush_pc;

    modport slave (
        input  in_valid, in_we, in_waddr, in_wdata, in_pc, in_exc, in_ertn, in_refetch, rf_ready,
        output in_ready, rf_we, rf_waddr, rf_wdata, commit_valid, commit_pc,
               flush, flush_excep, flush_ertn, flush_refetch, exc_idx, flush_pc
    );
    modport master (
        output in_valid, in_we, in_waddr, in_wdata, in_pc, in_exc, in_ertn, in_refetch, rf_ready,
        input  in_ready, rf_we, rf_waddr, rf_wdata, commit_valid, commit_pc,
               flush, flush_excep, flush_ertn, flush_refetch, exc_idx, flush_pc
    );
endinterface

// File: rtl/wb_retire_buf.sv
// wb_retire_buf: circular write-back buffer that retires entries in order and flushes on exceptional heads.
module wb_retire_buf #(
    parameter int XLEN   = 32,
    parameter int DEPTH  = 2,
    parameter int EXC_N  = 14,
    parameter int REG_AW = 5
) (
    input logic clk,
    input logic resetn,
    wb_retire_buf_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int EW = $clog2(EXC_N);

    logic              r_we      [DEPTH];
    logic [REG_AW-1:0] r_waddr   [DEPTH];
    logic [XLEN-1:0]   r_wdata   [DEPTH];
    logic [XLEN-1:0]   r_pc      [DEPTH];
    logic [EXC_N-1:0]  r_exc     [DEPTH];
    logic              r_ertn    [DEPTH];
    logic              r_refetch [DEPTH];
    logic [PW-1:0]     r_head;
    logic [PW-1:0]     r_tail;
    logic [PW:0]       r_count;

    logic              w_nonempty;
    logic [EXC_N-1:0]  w_head_exc;
    logic              w_exc_any;
    logic              w_exceptional;
    logic              w_flush;
    logic              w_retire;
    logic              w_push;
    logic [EW-1:0]     w_exc_idx;

    assign w_nonempty    = r_count != '0;
    assign w_head_exc    = r_exc[r_head];
    assign w_exc_any     = |w_head_exc;
    assign w_exceptional = w_exc_any | r_ertn[r_head] | r_refetch[r_head];
    assign w_flush       = w_nonempty & w_exceptional;
    assign w_retire      = w_nonempty & (w_exceptional | ~r_we[r_head] | bus.rf_ready);
    assign w_push        = bus.in_valid & bus.in_ready;

    // Scanning from the top lets the lowest set bit (highest priority) win.
    always_comb begin
        w_exc_idx = '0;
        for (int i = EXC_N - 1; i >= 0; i--)
            if (w_head_exc[i]) w_exc_idx = EW'(i);
    end

    assign bus.in_ready      = (r_count < (PW+1)'(DEPTH)) & ~w_flush;
    assign bus.rf_we         = w_retire & ~w_exceptional & r_we[r_head];
    assign bus.rf_waddr      = r_waddr[r_head];
    assign bus.rf_wdata      = r_wdata[r_head];
    assign bus.commit_valid  = w_retire;
    assign bus.commit_pc     = r_pc[r_head];
    assign bus.flush         = w_flush;
    assign bus.flush_excep   = w_flush & w_exc_any;
    assign bus.flush_ertn    = w_flush & ~w_exc_any & r_ertn[r_head];
    assign bus.flush_refetch = w_flush & ~w_exc_any & ~r_ertn[r_head] & r_refetch[r_head];
    assign bus.exc_idx       = w_nonempty ? w_exc_idx : '0;
    assign bus.flush_pc      = r_pc[r_head];

    // Payload storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_we[r_tail]      <= bus.in_we;
            r_waddr[r_tail]   <= bus.in_waddr;
            r_wdata[r_tail]   <= bus.in_wdata;
            r_pc[r_tail]      <= bus.in_pc;
            r_exc[r_tail]     <= bus.in_exc;
            r_ertn[r_tail]    <= bus.in_ertn;
            r_refetch[r_tail] <= bus.in_refetch;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (w_flush) begin
            r_head  <= r_tail;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + 1'b1;
            if (w_retire) r_head <= r_head + 1'b1;
            r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_retire);
        end
    end
endmodule

// File: tb/tb_wb_retire_buf.sv
// tb_wb_retire_buf: directed and random stimulus against a queue-based model of the retire buffer.
module tb_wb_retire_buf;
    localparam int XLEN = 32, DEPTH = 2, EXC_N = 14, REG_AW = 5;

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [31:0] pc;
        logic [13:0] exc;
        logic        ertn;
        logic        refetch;
    } ent_t;

    logic clk = 0;
    logic resetn = 0;
    int   n_chk = 0;
    int   n_err = 0;
    ent_t q[$];

    always #5 clk = ~clk;

    wb_retire_buf_if #(.XLEN(XLEN), .EXC_N(EXC_N), .REG_AW(REG_AW)) bus ();
    wb_retire_buf #(.XLEN(XLEN), .DEPTH(DEPTH), .EXC_N(EXC_N), .REG_AW(REG_AW)) dut (
        .clk(clk), .resetn(resetn), .bus(bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic ent_t mk(input logic we, input logic [31:0] pc, input logic [13:0] exc,
                                input logic ertn, input logic refetch);
        ent_t e;
        e.we = we; e.pc = pc; e.waddr = pc[4:0]; e.wdata = ~pc;
        e.exc = exc; e.ertn = ertn; e.refetch = refetch;
        return e;
    endfunction

    function automatic ent_t rnd_ent();
        return mk($urandom_range(0, 3) != 0, $urandom,
                  ($urandom_range(0, 9) == 0) ? 14'($urandom) : 14'd0,
                  $urandom_range(0, 14) == 0, $urandom_range(0, 14) == 0);
    endfunction

    // One clock: drive at negedge, compare against the model, then advance the model.
    task automatic step(input logic v, input ent_t e, input logic rfr);
        ent_t h = '{default: 0};
        logic emp, ex, fl, ret, rwe, rdy;
        int idx;
        @(negedge clk);
        bus.in_valid = v; bus.in_we = e.we; bus.in_waddr = e.waddr; bus.in_wdata = e.wdata;
        bus.in_pc = e.pc; bus.in_exc = e.exc; bus.in_ertn = e.ertn; bus.in_refetch = e.refetch;
        bus.rf_ready = rfr;
        #1;
        emp = q.size() == 0;
        ex = 0;
        idx = 0;
        if (!emp) begin
            h = q[0];
            ex = (h.exc != 0) || h.ertn || h.refetch;
            if (h.exc != 0) while (h.exc[idx] == 1'b0) idx++;
        end
        fl  = !emp && ex;
        ret = !emp && (ex || !h.we || rfr);
        rwe = ret && !ex && h.we;
        rdy = q.size() < DEPTH && !fl;
        check("in_ready", bus.in_ready, rdy);
        check("commit_valid", bus.commit_valid, ret);
        check("rf_we", bus.rf_we, rwe);
        check("flush", bus.flush, fl);
        check("flush_excep", bus.flush_excep, fl && h.exc != 0);
        check("flush_ertn", bus.flush_ertn, fl && h.exc == 0 && h.ertn);
        check("flush_refetch", bus.flush_refetch, fl && h.exc == 0 && !h.ertn && h.refetch);
        check("exc_idx", bus.exc_idx, idx);
        if (ret) check("commit_pc", bus.commit_pc, h.pc);
        if (fl) check("flush_pc", bus.flush_pc, h.pc);
        if (!emp) begin
            check("rf_waddr", bus.rf_waddr, h.waddr);
            check("rf_wdata", bus.rf_wdata, h.wdata);
        end
        if (fl) q.delete();
        else begin
            if (ret) void'(q.pop_front());
            if (v && rdy) q.push_back(e);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 0;
        bus.in_valid = 0;
        bus.rf_ready = 0;
        @(posedge clk);
        #1 resetn = 1;
        q.delete();
    endtask

    ent_t idle;

    initial begin
        idle = mk(0, 0, 0, 0, 0);
        bus.in_valid = 0; bus.in_we = 0; bus.in_waddr = 0; bus.in_wdata = 0; bus.in_pc = 0;
        bus.in_exc = 0; bus.in_ertn = 0; bus.in_refetch = 0; bus.rf_ready = 0;
        do_reset();
        step(0, idle, 0);
        // Fill with rf_ready low: third entry is held upstream.
        step(1, mk(1, 32'h100, 0, 0, 0), 0);
        step(1, mk(1, 32'h104, 0, 0, 0), 0);
        step(1, mk(1, 32'h108, 0, 0, 0), 0);
        step(1, mk(1, 32'h108, 0, 0, 0), 0);
        // Drain in order once rf_ready rises.
        step(0, idle, 1);
        step(0, idle, 1);
        step(0, idle, 1);
        // Exception (idx 2) queued behind a blocked write, with a younger entry waiting upstream.
        step(1, mk(1, 32'h200, 0, 0, 0), 0);
        step(1, mk(1, 32'h204, 14'b00_0000_0010_0100, 0, 0), 0);
        step(0, idle, 1);
        step(1, mk(1, 32'h208, 0, 0, 0), 0);
        step(1, mk(1, 32'h208, 0, 0, 0), 0);
        step(0, idle, 1);
        // ertn beats refetch.
        step(1, mk(1, 32'h300, 0, 1, 1), 0);
        step(0, idle, 0);
        // Pointer wrap through ten push/retire pairs.
        for (int i = 0; i < 10; i++) step(1, mk(i[0], 32'h400 + 4 * i, 0, 0, 0), 1);
        step(0, idle, 1);
        // Reset while full.
        step(1, mk(1, 32'h500, 0, 0, 0), 0);
        step(1, mk(1, 32'h504, 0, 0, 0), 0);
        do_reset();
        step(0, idle, 1);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            step($urandom_range(0, 9) < 7, rnd_ent(), $urandom_range(0, 1) == 1);
        end
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/wb_retire_buf.md
WB_RETIRE_BUF -- requirements
Module: wb_retire_buf

Interface
REQ-001 Parameter XLEN, default 32, width of the data and PC fields.
REQ-002 Parameter DEPTH, default 2, number of buffer entries; power of two, at least 2.
REQ-003 Parameter EXC_N, default 14, number of exception cause bits; bit 0 has the highest priority.
REQ-004 Parameter REG_AW, default 5, register-file address width.
REQ-005 clk  in  1  clock; reset resetn, synchronous, active-low.
REQ-006 in_valid  in  1  upstream entry valid.
REQ-007 in_ready  out  1  buffer accepts an entry this cycle.
REQ-008 in_we, in_waddr, in_wdata, in_pc  in  1/REG_AW/XLEN/XLEN  register-file write request, destination, data, and PC.
REQ-009 in_exc  in  EXC_N  exception cause vector; in_ertn  in  1  ertn marker; in_refetch  in  1  TLB/CSR refetch marker.
REQ-010 rf_ready  in  1  register-file write port free this cycle.
REQ-011 rf_we, rf_waddr, rf_wdata  out  1/REG_AW/XLEN  register-file write port.
REQ-012 commit_valid, commit_pc  out  1/XLEN  head entry retires this cycle, and its PC.
REQ-013 flush, flush_excep, flush_ertn, flush_refetch  out  1 each  pipeline flush pulse and its cause.
REQ-014 exc_idx  out  clog2(EXC_N)  index of the winning cause; flush_pc  out  XLEN  PC of the flushing entry.

Function
REQ-015 Circular FIFO: head pointer, tail pointer, and count of width clog2(DEPTH)+1; pointers wrap modulo DEPTH.
REQ-016 in_ready = (count < DEPTH) & ~flush; there is no same-cycle pop-to-push bypass.
REQ-017 A push occurs when in_valid & in_ready; the entry is written at tail; tail increments.
REQ-018 Latency: an entry pushed at cycle N becomes head no earlier than cycle N+1; the buffer has no combinational path from in_* to the rf_*, commit_*, or flush_* outputs.
REQ-019 The head is "exceptional" when |in_exc (stored with the entry), ertn, or refetch is set.
REQ-020 Non-exceptional head with we=1 retires only when rf_ready=1; with we=0 it retires unconditionally.
REQ-021 On retire: commit_valid=1, commit_pc=head PC, rf_we=head we, head increments, count decrements.
REQ-022 Exceptional head retires in its first head cycle regardless of rf_ready; rf_we=0 for that entry.
REQ-023 Exceptional head drives flush=1 for exactly one cycle; flush_pc=head PC.
REQ-024 Flush cause priority: exception over ertn over refetch; exactly one of flush_excep, flush_ertn, flush_refetch is 1.
REQ-025 exc_idx = index of the lowest set in_exc bit of the head; 0 when no exception.
REQ-026 On flush, all entries behind the head are discarded: count←0, head←tail; a push in the flush cycle cannot occur (REQ-016).
REQ-027 Simultaneous push and retire: count unchanged, both pointers advance.
REQ-028 Empty buffer: commit_valid=0, rf_we=0, flush=0; rf_waddr, rf_wdata, and commit_pc hold the head-slot contents (don't-care).
REQ-029 rf_waddr and rf_wdata always reflect the head entry; rf_we=0 whenever commit_valid=0.

Reset
REQ-030 Reset clears head, tail, count, and flush to 0; after reset in_ready=1 and all other 1-bit outputs are 0.
REQ-031 Reset asserted mid-operation discards all entries on the next clock edge; entry payload storage is not reset.

Verification
REQ-032 DEPTH=2, push 3 back-to-back entries with rf_ready=0 -> in_ready falls after the 2nd push; the 3rd entry is held upstream; count=2.
REQ-033 Full buffer, rf_ready rises -> one retire per cycle: rf_we=1 with waddr and wdata in push order; in_ready=1 the cycle after the first retire.
REQ-034 Head with in_exc=14'b00_0000_0010_0100 and 1 younger entry queued -> flush=1 for 1 cycle, flush_excep=1, exc_idx=2, rf_we=0; younger entry dropped; count=0 next cycle.
REQ-035 Head with ertn=1 and refetch=1 -> flush_ertn=1, flush_refetch=0, flush_pc=head PC.
REQ-036 Pointer wrap: 10 sequential push/retire pairs with DEPTH=2 -> commit_pc sequence equals push order; count never exceeds 2.
REQ-037 Reset asserted while count=2 -> the next cycle has count=0, in_ready=1, and commit_valid=0.
